fifo_rd_dispatch: RTL and testbench
===================================

# fifo_rd_dispatch

Read-side dispatcher for the multi-port ingress FIFO bank. Consumes the 8-bit FIFO selection code (bit 7 = valid, bits 6:0 = port index) from the port arbiter, locks onto the chosen port, and drains exactly one length-prefixed packet from it onto a single valid/ready output stream. When the packet completes, the lock releases and the next selection is accepted.

## Interface
- PORT_NUM, 12, number of FIFO ports (1..127)
- DATA_W, 32, FIFO/stream word width
- LEN_W, 12, payload-length field width in header word bits [LEN_W-1:0] (LEN_W <= DATA_W)
- glb_clk  in  1  single clock, all logic rising-edge
- glb_areset  in  1  reset, asynchronous, active-high
- fifo_sel_code  in  8  selection code: [7] valid, [6:0] port index
- fifo_empty  in  PORT_NUM  per-port empty flags
- fifo_rd_en  out  PORT_NUM  one-hot read strobe, at most one bit high
- fifo_rd_data  in  PORT_NUM*DATA_W  port p data at [p*DATA_W +: DATA_W], valid the cycle after its rd_en
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  output word
- out_sop  out  1  first word (header) of packet
- out_eop  out  1  last word of packet
- sel_busy  out  1  port locked, packet in progress
- sel_done  out  1  one-cycle pulse, packet fully delivered
- sel_err  out  1  one-cycle pulse, valid code with index >= PORT_NUM

## Operation
- Packet = header word + N payload words, N = header[LEN_W-1:0]; N = 0 is legal (header-only). Header is forwarded as the first output word.
- States: IDLE, HDR, HWAIT, PAYLOAD, DRAIN.
- IDLE: if fifo_sel_code[7]=1 and index < PORT_NUM, capture index, sel_busy=1, go HDR. If index >= PORT_NUM, pulse sel_err, stay IDLE. fifo_sel_code is ignored in every other state.
- HDR: issue one read (fifo_rd_en[idx]=1) when !fifo_empty[idx] and credit available; go HWAIT.
- HWAIT: header returns; load remaining-counter rem = N; go PAYLOAD if N != 0, else DRAIN.
- PAYLOAD: read when rem != 0, !fifo_empty[idx], credit available; decrement rem per read; the read that takes rem to 0 moves to DRAIN.
- DRAIN: wait for output buffer empty and no read in flight; then pulse sel_done, clear sel_busy, return to IDLE.
- Credit: 2-entry output buffer; a read is issued only if (buffered words + reads in flight) < 2. No word is ever dropped or duplicated under any out_ready pattern.
- out_sop on the header word; out_eop on word N (header when N = 0). The header carries both when N = 0.
- Output transfer occurs when out_valid && out_ready; out_data/sop/eop hold stable while out_valid && !out_ready.
- Reset mid-packet: all state cleared, partial packet abandoned, no sel_done/sel_err.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, sel_busy=0, sel_done=0, sel_err=0; state IDLE, rem=0, buffer empty.
- Selection captured in cycle T: sel_busy high from T+1. Earliest header fifo_rd_en is T+1, and header out_valid is T+3.
- Read latency: rd_en in cycle C, fifo_rd_data sampled in C+1, word on out_data from C+2.
- Steady-state throughput: 1 word/cycle with out_ready=1 and FIFO non-empty. There is one bubble after the header read (HWAIT).
- sel_done asserts the cycle after the eop word is accepted. The earliest new capture is in the same cycle as sel_done (state IDLE).
- sel_err asserts the cycle after the invalid code is sampled in IDLE. It re-pulses every cycle the invalid code persists.

## Test plan
- Port 3, header N=4, out_ready=1: code 0x83 -> rd_en[3] pulses 5 times, 5 output words, sop on word 0, eop on word 4, sel_done 1 cycle after eop, sel_busy low next.
- Port 0, header N=0: code 0x80 -> single output word with sop=eop=1, exactly one rd_en[0], sel_done follows.
- Backpressure: port 11, N=6, out_ready toggled 1/0 pseudo-randomly -> 7 words in order, none lost or duplicated, data held while stalled, rd_en never with buffer+inflight = 2.
- FIFO underflow: port 5 empty mid-payload for 3 cycles -> rd_en[5] low while empty, resumes, packet intact; fifo_sel_code changed to 0x82 mid-packet -> ignored until sel_done.
- Invalid index: code 0x8C with PORT_NUM=12 -> sel_err pulse, no rd_en, sel_busy stays 0; code 0x00 -> nothing.
- glb_areset asserted after 2 of 8 payload words -> all outputs 0 immediately, state IDLE. A new code 0x81 after release starts a clean packet.

Source files
------------

// File: rtl/fifo_rd_dispatch.sv
// Read-side dispatcher: locks onto the port chosen by the arbiter and drains one
// length-prefixed packet from it onto a valid/ready stream through a 2-entry buffer.
module fifo_rd_dispatch #(
  parameter int unsigned PORT_NUM = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LEN_W    = 12
) (
  input  logic                         glb_clk,
  input  logic                         glb_areset,
  input  logic [7:0]                   fifo_sel_code,
  input  logic [PORT_NUM-1:0]          fifo_empty,
  output logic [PORT_NUM-1:0]          fifo_rd_en,
  input  logic [PORT_NUM*DATA_W-1:0]   fifo_rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic                         sel_busy,
  output logic                         sel_done,
  output logic                         sel_err
);

  localparam int unsigned IDX_W = 7;
  localparam int unsigned OCC_W = 3;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_HWAIT   = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [LEN_W-1:0]  rem, rem_nxt;
  logic              busy_nxt, done_nxt, err_nxt;
  logic              rd, rd_hdr, rd_last;

  logic              rd_pend, pend_hdr, pend_last;
  logic              port_empty;
  logic [DATA_W-1:0] rd_word;
  logic [LEN_W-1:0]  hdr_len;
  logic [IDX_W-1:0]  code_idx;

  logic              b1_valid, b1_sop, b1_eop;
  logic [DATA_W-1:0] b1_data;
  logic              h_v, h_s, h_e, t_v, t_s, t_e;
  logic [DATA_W-1:0] h_d, t_d;
  logic              in_sop, in_eop;
  logic              pop, credit;
  logic [OCC_W-1:0]  occ;

  assign code_idx = fifo_sel_code[6:0];
  assign hdr_len  = rd_word[LEN_W-1:0];

  // Route the locked port's empty flag and returning data.
  always_comb begin
    port_empty = 1'b1;
    rd_word    = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (idx == IDX_W'(p)) begin
        port_empty = fifo_empty[p];
        rd_word    = fifo_rd_data[p*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    fifo_rd_en = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      fifo_rd_en[p] = rd && (idx == IDX_W'(p));
    end
  end

  // Occupancy after this cycle's departure plus the read already in flight.
  assign pop    = out_valid && out_ready;
  assign occ    = OCC_W'(out_valid) + OCC_W'(b1_valid) - OCC_W'(pop);
  assign credit = (occ + OCC_W'(rd_pend)) < OCC_W'(2);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rem_nxt   = rem;
    busy_nxt  = sel_busy;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    rd        = 1'b0;
    rd_hdr    = 1'b0;
    rd_last   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_sel_code[7]) begin
          if (code_idx < IDX_W'(PORT_NUM)) begin
            idx_nxt   = code_idx;
            busy_nxt  = 1'b1;
            state_nxt = S_HDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (!port_empty && credit) begin
          rd        = 1'b1;
          rd_hdr    = 1'b1;
          state_nxt = S_HWAIT;
        end
      end
      S_HWAIT: begin
        // Header word is on the bus this cycle; it sets the payload count.
        rem_nxt   = hdr_len;
        state_nxt = (hdr_len != '0) ? S_PAYLOAD : S_DRAIN;
      end
      S_PAYLOAD: begin
        if ((rem != '0) && !port_empty && credit) begin
          rd      = 1'b1;
          rem_nxt = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            rd_last   = 1'b1;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if ((occ == '0) && !rd_pend) begin
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      state     <= S_IDLE;
      idx       <= '0;
      rem       <= '0;
      sel_busy  <= 1'b0;
      sel_done  <= 1'b0;
      sel_err   <= 1'b0;
      rd_pend   <= 1'b0;
      pend_hdr  <= 1'b0;
      pend_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      rem       <= rem_nxt;
      sel_busy  <= busy_nxt;
      sel_done  <= done_nxt;
      sel_err   <= err_nxt;
      rd_pend   <= rd;
      pend_hdr  <= rd_hdr;
      pend_last <= rd_last;
    end
  end

  // Header-only packets carry eop on the header itself.
  assign in_sop = pend_hdr;
  assign in_eop = pend_hdr ? (hdr_len == '0) : pend_last;

  // Two-entry buffer: head entry drives the stream, tail entry absorbs stalls.
  always_comb begin
    h_v = out_valid;
    h_d = out_data;
    h_s = out_sop;
    h_e = out_eop;
    t_v = b1_valid;
    t_d = b1_data;
    t_s = b1_sop;
    t_e = b1_eop;
    if (pop) begin
      h_v = t_v;
      h_d = t_d;
      h_s = t_s;
      h_e = t_e;
      t_v = 1'b0;
    end
    if (rd_pend) begin
      if (!h_v) begin
        h_v = 1'b1;
        h_d = rd_word;
        h_s = in_sop;
        h_e = in_eop;
      end else begin
        t_v = 1'b1;
        t_d = rd_word;
        t_s = in_sop;
        t_e = in_eop;
      end
    end
  end

  always_ff @(posedge glb_clk or posedge glb_areset) begin
    if (glb_areset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      b1_valid  <= 1'b0;
      b1_data   <= '0;
      b1_sop    <= 1'b0;
      b1_eop    <= 1'b0;
    end else begin
      out_valid <= h_v;
      out_data  <= h_d;
      out_sop   <= h_s;
      out_eop   <= h_e;
      b1_valid  <= t_v;
      b1_data   <= t_d;
      b1_sop    <= t_s;
      b1_eop    <= t_e;
    end
  end

endmodule

// File: tb/tb_fifo_rd_dispatch.sv
// Directed bench for fifo_rd_dispatch with a behavioural FIFO bank and stream monitor.
module tb_fifo_rd_dispatch;

  localparam int PN = 12;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       code = 8'h00;
  logic [PN-1:0]    fifo_empty;
  logic [PN-1:0]    rd_en;
  logic [PN*DW-1:0] rd_data = '0;
  logic             out_valid, out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic             sop, eop, busy, done, err;

  int checks = 0;
  int failures = 0;

  fifo_rd_dispatch #(.PORT_NUM(PN), .DATA_W(DW), .LEN_W(12)) dut (
    .glb_clk(clk), .glb_areset(rst), .fifo_sel_code(code),
    .fifo_empty(fifo_empty), .fifo_rd_en(rd_en), .fifo_rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(sop), .out_eop(eop), .sel_busy(busy), .sel_done(done), .sel_err(err)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO bank: data appears the cycle after the read strobe.
  logic [DW-1:0] mem [PN][32];
  int            wrp [PN];
  int            rdp [PN];
  logic [PN-1:0] fe_force = '0;

  always_comb begin
    for (int p = 0; p < PN; p++) fifo_empty[p] = (rdp[p] == wrp[p]) || fe_force[p];
  end

  always @(posedge clk) begin
    for (int p = 0; p < PN; p++) begin
      if (rd_en[p] && (rdp[p] != wrp[p])) begin
        rd_data[p*DW +: DW] <= mem[p][rdp[p] % 32];
        rdp[p] <= rdp[p] + 1;
      end
    end
  end

  // Stream monitor.
  int          cyc = 0, n_done = 0, n_err = 0, eop_cyc = -1, done_cyc = -1;
  int          n_rd [PN];
  int          credit_viol = 0, hold_viol = 0, uf_viol = 0, oh_viol = 0;
  int          tot_iss = 0, tot_acc = 0;
  bit          acc, stall_p = 1'b0;
  logic [33:0] held;
  logic [33:0] cap [$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      tot_iss = 0;
      tot_acc = 0;
      stall_p = 1'b0;
    end else begin
      acc = out_valid && out_ready;
      if (|rd_en) begin
        if (tot_iss - tot_acc - int'(acc) + 1 > 2) credit_viol++;
        tot_iss++;
      end
      if (acc) begin
        tot_acc++;
        cap.push_back({sop, eop, out_data});
        if (eop) eop_cyc = cyc;
      end
      if ($countones(rd_en) > 1) oh_viol++;
      for (int p = 0; p < PN; p++) begin
        if (rd_en[p]) begin
          n_rd[p]++;
          if (fifo_empty[p]) uf_viol++;
        end
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (err) n_err++;
      if (stall_p && (!out_valid || ({sop, eop, out_data} != held))) hold_viol++;
      stall_p = out_valid && !out_ready;
      held    = {sop, eop, out_data};
    end
  end

  function automatic logic [33:0] exp_word(input logic [19:0] tag, input int n, input int i);
    logic [31:0] d;
    d = (i == 0) ? {tag, 12'(n)} : {~tag, 12'(i)};
    return {(i == 0), (i == n), d};
  endfunction

  task automatic load(input int p, input int n, input logic [19:0] tag);
    logic [33:0] w;
    for (int i = 0; i <= n; i++) begin
      w = exp_word(tag, n, i);
      mem[p][wrp[p] % 32] = w[31:0];
      wrp[p]++;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (rd_en !== '0) begin failures++; $display("FAIL reset_rd_en got=%h exp=0", rd_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    checks++; if ({sop, eop} !== 2'b00) begin failures++; $display("FAIL reset_sop_eop got=%b exp=00", {sop, eop}); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL reset_sel got=%b exp=000", {busy, done, err}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    int c0, r0, nc;
    bit ok;
    logic [33:0] e;
    c0 = cap.size(); r0 = n_rd[3];
    load(3, 4, 20'h3A3A3);
    code = 8'h83;
    @(negedge clk);
    code = 8'h00;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    checks++; if (rd_en !== 12'h008) begin failures++; $display("FAIL basic_hdr_rd got=%h exp=008", rd_en); end
    @(negedge clk);
    checks++; if (rd_en !== '0) begin failures++; $display("FAIL basic_hwait_bubble got=%h exp=0", rd_en); end
    @(negedge clk);
    e = exp_word(20'h3A3A3, 4, 0);
    checks++;
    if ({out_valid, sop, eop, out_data} !== {1'b1, e}) begin
      failures++; $display("FAIL basic_hdr_out got=%b%b%b_%h exp=1%b_%h", out_valid, sop, eop, out_data, e[33:32], e[31:0]);
    end
    wait_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 exp=1"); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_clear got=%b exp=0", busy); end
    nc = cap.size() - c0;
    checks++; if (nc != 5) begin failures++; $display("FAIL basic_word_count got=%0d exp=5", nc); end
    for (int i = 0; i < 5; i++) begin
      e = exp_word(20'h3A3A3, 4, i);
      if (c0 + i < cap.size()) begin
        checks++;
        if (cap[c0+i] !== e) begin failures++; $display("FAIL basic_word%0d got=%h exp=%h", i, cap[c0+i], e); end
      end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (n_rd[3] - r0 != 5) begin failures++; $display("FAIL basic_rd_count got=%0d exp=5", n_rd[3] - r0); end
    checks++; if (done_cyc != eop_cyc + 1) begin failures++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, eop_cyc + 1); end
  endtask

  task automatic test_header_only();
    int c0, r0;
    bit ok;
    logic [33:0] e;
    c0 = cap.size(); r0 = n_rd[0];
    load(0, 0, 20'h0F00D);
    code = 8'h80;
    @(negedge clk);
    code = 8'h00;
    wait_done(30, ok);
    checks++; if (!ok) begin failures++; $display("FAIL hdronly_done_timeout got=0 exp=1"); end
    @(negedge clk);
    e = exp_word(20'h0F00D, 0, 0);
    checks++; if (cap.size() - c0 != 1) begin failures++; $display("FAIL hdronly_count got=%0d exp=1", cap.size() - c0); end
    if (cap.size() > c0) begin
      checks++; if (cap[c0] !== e) begin failures++; $display("FAIL hdronly_word got=%h exp=%h", cap[c0], e); end
    end
    checks++; if (n_rd[0] - r0 != 1) begin failures++; $display("FAIL hdronly_rd_count got=%0d exp=1", n_rd[0] - r0); end
  endtask

  task automatic test_backpressure();
    int c0, r0, h0, cr0;
    bit ok;
    logic [15:0] pat;
    logic [33:0] e;
    pat = 16'hB2C5;
    c0 = cap.size(); r0 = n_rd[11]; h0 = hold_viol; cr0 = credit_viol;
    load(11, 6, 20'hBEEF1);
    code = 8'h8B;
    @(negedge clk);
    code = 8'h00;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      out_ready = pat[k % 16];
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 exp=1"); end
    checks++; if (cap.size() - c0 != 7) begin failures++; $display("FAIL bp_count got=%0d exp=7", cap.size() - c0); end
    for (int i = 0; i < 7; i++) begin
      e = exp_word(20'hBEEF1, 6, i);
      if (c0 + i < cap.size()) begin
        checks++;
        if (cap[c0+i] !== e) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, cap[c0+i], e); end
      end
    end
    checks++; if (hold_viol != h0) begin failures++; $display("FAIL bp_hold got=%0d exp=%0d", hold_viol, h0); end
    checks++; if (credit_viol != cr0) begin failures++; $display("FAIL bp_credit got=%0d exp=%0d", credit_viol, cr0); end
    checks++; if (n_rd[11] - r0 != 7) begin failures++; $display("FAIL bp_rd_count got=%0d exp=7", n_rd[11] - r0); end
  endtask

  task automatic test_underflow_and_ignore();
    int c0, r0, r2, u0;
    bit ok;
    logic [33:0] e;
    c0 = cap.size(); r0 = n_rd[5]; r2 = n_rd[2]; u0 = uf_viol;
    load(5, 5, 20'h55555);
    load(2, 0, 20'h22222);
    code = 8'h85;
    @(negedge clk);
    code = 8'h82;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (n_rd[5] - r0 >= 3) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!ok) begin failures++; $display("FAIL uf_reach_timeout got=0 exp=1"); end
    fe_force[5] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rd_en[5] !== 1'b0) begin failures++; $display("FAIL uf_rd_while_empty%0d got=1 exp=0", k); end
      @(negedge clk);
    end
    fe_force[5] = 1'b0;
    wait_done(50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL uf_done_timeout got=0 exp=1"); end
    checks++; if (n_rd[2] != r2) begin failures++; $display("FAIL uf_code_ignored got=%0d exp=%0d", n_rd[2], r2); end
    checks++; if (cap.size() - c0 != 6) begin failures++; $display("FAIL uf_count got=%0d exp=6", cap.size() - c0); end
    for (int i = 0; i < 6; i++) begin
      e = exp_word(20'h55555, 5, i);
      if (c0 + i < cap.size()) begin
        checks++;
        if (cap[c0+i] !== e) begin failures++; $display("FAIL uf_word%0d got=%h exp=%h", i, cap[c0+i], e); end
      end
    end
    @(negedge clk);
    code = 8'h00;
    wait_done(30, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL uf_port2_timeout got=0 exp=1"); end
    e = exp_word(20'h22222, 0, 0);
    checks++; if (cap.size() - c0 != 7) begin failures++; $display("FAIL uf_port2_count got=%0d exp=7", cap.size() - c0); end
    if (cap.size() > c0 + 6) begin
      checks++; if (cap[c0+6] !== e) begin failures++; $display("FAIL uf_port2_word got=%h exp=%h", cap[c0+6], e); end
    end
    checks++; if (uf_viol != u0) begin failures++; $display("FAIL uf_empty_read got=%0d exp=%0d", uf_viol, u0); end
  endtask

  task automatic test_invalid_index();
    int e0, s0, s1;
    e0 = n_err; s0 = 0; s1 = 0;
    for (int p = 0; p < PN; p++) s0 += n_rd[p];
    code = 8'h8C;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL inv_err%0d got=%b exp=1", k, err); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inv_busy%0d got=%b exp=0", k, busy); end
      checks++; if (rd_en !== '0) begin failures++; $display("FAIL inv_rd%0d got=%h exp=0", k, rd_en); end
    end
    code = 8'h00;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if ({err, busy} !== 2'b00) begin failures++; $display("FAIL inv_zero_code%0d got=%b exp=00", k, {err, busy}); end
    end
    for (int p = 0; p < PN; p++) s1 += n_rd[p];
    checks++; if (n_err - e0 != 3) begin failures++; $display("FAIL inv_err_count got=%0d exp=3", n_err - e0); end
    checks++; if (s1 != s0) begin failures++; $display("FAIL inv_no_reads got=%0d exp=%0d", s1, s0); end
  endtask

  task automatic test_reset_mid_packet();
    int c0, d0;
    bit ok;
    logic [33:0] e;
    c0 = cap.size();
    load(7, 8, 20'h77777);
    load(1, 2, 20'h11111);
    code = 8'h87;
    @(negedge clk);
    code = 8'h00;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (cap.size() - c0 >= 3) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach_timeout got=0 exp=1"); end
    d0 = n_done;
    rst = 1'b1;
    #1;
    checks++; if (rd_en !== '0) begin failures++; $display("FAIL rstmid_rd_en got=%h exp=0", rd_en); end
    checks++; if ({out_valid, sop, eop} !== 3'b000) begin failures++; $display("FAIL rstmid_stream got=%b exp=000", {out_valid, sop, eop}); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
    checks++; if ({busy, done, err} !== 3'b000) begin failures++; $display("FAIL rstmid_sel got=%b exp=000", {busy, done, err}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({busy, done, out_valid} !== 3'b000) begin failures++; $display("FAIL rstmid_after got=%b exp=000", {busy, done, out_valid}); end
    checks++; if (n_done != d0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=%0d", n_done, d0); end
    c0 = cap.size();
    code = 8'h81;
    @(negedge clk);
    code = 8'h00;
    wait_done(40, ok);
    @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_new_timeout got=0 exp=1"); end
    checks++; if (cap.size() - c0 != 3) begin failures++; $display("FAIL rstmid_new_count got=%0d exp=3", cap.size() - c0); end
    for (int i = 0; i < 3; i++) begin
      e = exp_word(20'h11111, 2, i);
      if (c0 + i < cap.size()) begin
        checks++;
        if (cap[c0+i] !== e) begin failures++; $display("FAIL rstmid_new_word%0d got=%h exp=%h", i, cap[c0+i], e); end
      end
    end
    checks++; if (oh_viol != 0) begin failures++; $display("FAIL onehot_rd_en got=%0d exp=0", oh_viol); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_header_only();
    test_backpressure();
    test_underflow_and_ignore();
    test_invalid_index();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
